// File: rtl/bit_source_pkg.sv
// bit_source_pkg
// Shared types and helpers for the bit-source arbiter.
//   src_entry_t  : layout of one buffered fragment at the default widths
//   arb_state_t  : priority-mode lock state
//   ARB_ORDERED / ARB_PRIORITY : values of the ARB_MODE parameter
//   clamp_size() : limits a producer's size_of_bit to the fragment width
package bit_source_pkg;

   localparam int DEFAULT_VAL_W  = 64;
   localparam int DEFAULT_SIZE_W = 7;

   localparam int ARB_ORDERED  = 0;
   localparam int ARB_PRIORITY = 1;

   // FIFO words are stored as a flat vector in this same {flush, size, val}
   // order, so that non-default widths work without a new typedef.
   typedef struct packed {
      logic                      flush;
      logic [DEFAULT_SIZE_W-1:0] size;
      logic [DEFAULT_VAL_W-1:0]  val;
   } src_entry_t;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   function automatic logic [63:0] clamp_size(input logic [63:0] size,
                                              input logic [63:0] limit);
      return (size > limit) ? limit : size;
   endfunction

endpackage

// File: rtl/bit_source_fifo.sv
// bit_source_fifo
// Single-clock FIFO holding the fragments of one producer.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, wr_data: write request and word
//   pop, rd_data : read request and head word (head is valid while !empty)
//   full, empty  : occupancy flags
// A push while full is accepted only when a pop frees a slot in the same cycle.
module bit_source_fifo #(
   parameter int WIDTH = 72,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bit_source_arbiter.sv
// bit_source_arbiter
// Buffers NUM_SRC bitstream producers in private FIFOs and drains them into one
// registered fragment stream for set_bit.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   seq_restart         : new frame; resets pointer/lock and bit_count
//   src_enable/flush    : per-channel fragment valid / end-of-run marker
//   src_val, src_size_of_bit : packed per-channel fragment and size
//   out_ready           : sink accepts a fragment this cycle
//   out_*               : registered fragment, all-zero when nothing is popped
//   out_channel         : channel of the most recent popped fragment
//   src_full            : per-channel FIFO full
//   overflow, size_err  : sticky per-channel error flags
//   bit_count           : bits emitted since reset/seq_restart (wraps)
module bit_source_arbiter
   import bit_source_pkg::*;
#(
   parameter int NUM_SRC    = 8,
   parameter int VAL_W      = 64,
   parameter int SIZE_W     = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       seq_restart,
   input  logic [NUM_SRC-1:0]         src_enable,
   input  logic [NUM_SRC-1:0]         src_flush,
   input  logic [NUM_SRC*VAL_W-1:0]   src_val,
   input  logic [NUM_SRC*64-1:0]      src_size_of_bit,
   input  logic                       out_ready,
   output logic                       out_enable,
   output logic [63:0]                out_val,
   output logic [63:0]                out_size_of_bit,
   output logic                       out_flush,
   output logic [$clog2(NUM_SRC)-1:0] out_channel,
   output logic [NUM_SRC-1:0]         src_full,
   output logic [NUM_SRC-1:0]         overflow,
   output logic [NUM_SRC-1:0]         size_err,
   output logic [31:0]                bit_count
);
   localparam int CH_W    = $clog2(NUM_SRC);
   localparam int ENTRY_W = 1 + SIZE_W + VAL_W;

   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] ovf_set;
   logic [NUM_SRC-1:0] size_set;
   logic [ENTRY_W-1:0] wr_data [NUM_SRC];
   logic [ENTRY_W-1:0] rd_data [NUM_SRC];

   logic [CH_W-1:0]    ptr_reg;
   logic [CH_W-1:0]    lock_ch_reg;
   arb_state_t         state_reg;

   logic [CH_W-1:0]    sel;
   logic               sel_valid;
   logic               pop_any;
   logic [ENTRY_W-1:0] sel_entry;
   logic               sel_flush;
   logic [SIZE_W-1:0]  sel_size;
   logic [VAL_W-1:0]   sel_val;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ch
      assign push[gi]     = src_enable[gi] | src_flush[gi];
      assign size_set[gi] = src_enable[gi] &&
                            (src_size_of_bit[gi*64 +: 64] > 64'(VAL_W));
      // A flush-only push carries no payload: size and val are forced to zero.
      assign wr_data[gi]  = {src_flush[gi],
                             src_enable[gi] ? SIZE_W'(clamp_size(src_size_of_bit[gi*64 +: 64],
                                                                 64'(VAL_W)))
                                            : SIZE_W'(0),
                             src_enable[gi] ? src_val[gi*VAL_W +: VAL_W] : VAL_W'(0)};
      assign pop[gi]      = pop_any && (sel == CH_W'(gi));
      // The FIFO itself absorbs a push-on-full when the same cycle pops it.
      assign ovf_set[gi]  = push[gi] && full[gi] && !pop[gi];

      bit_source_fifo #(
         .WIDTH (ENTRY_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clock   (clock),
         .reset   (reset),
         .push    (push[gi]),
         .wr_data (wr_data[gi]),
         .pop     (pop[gi]),
         .rd_data (rd_data[gi]),
         .full    (full[gi]),
         .empty   (empty[gi])
      );
   end

   assign src_full = full;

   // Channel selection: ordered mode follows the pointer; priority mode takes
   // the locked channel, or else the lowest-index non-empty one.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      if (ARB_MODE == ARB_ORDERED) begin
         sel       = ptr_reg;
         sel_valid = 1'b1;
      end else if (state_reg == ARB_LOCKED) begin
         sel       = lock_ch_reg;
         sel_valid = 1'b1;
      end else begin
         for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!empty[i]) begin
               sel       = CH_W'(i);
               sel_valid = 1'b1;
            end
         end
      end
   end

   assign pop_any   = out_ready && sel_valid && !empty[sel];
   assign sel_entry = rd_data[sel];
   assign sel_flush = sel_entry[ENTRY_W-1];
   assign sel_size  = sel_entry[VAL_W +: SIZE_W];
   assign sel_val   = sel_entry[VAL_W-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_enable      <= 1'b0;
         out_flush       <= 1'b0;
         out_val         <= '0;
         out_size_of_bit <= '0;
         out_channel     <= '0;
         overflow        <= '0;
         size_err        <= '0;
         bit_count       <= '0;
         ptr_reg         <= '0;
         lock_ch_reg     <= '0;
         state_reg       <= ARB_IDLE;
      end else begin
         // Idle cycles present all-zero fragments so the stream stays OR-mergeable.
         out_enable      <= pop_any && (sel_size != '0);
         out_flush       <= pop_any && sel_flush;
         out_val         <= pop_any ? 64'(sel_val) : 64'(0);
         out_size_of_bit <= pop_any ? 64'(sel_size) : 64'(0);
         if (pop_any) begin
            out_channel <= sel;
         end
         overflow <= overflow | ovf_set;
         size_err <= size_err | size_set;

         // Restart overrides the arbitration update and the count of a
         // coincident pop; the popped fragment itself still goes out.
         if (seq_restart) begin
            ptr_reg   <= '0;
            state_reg <= ARB_IDLE;
            bit_count <= '0;
         end else if (pop_any) begin
            bit_count <= bit_count + 32'(sel_size);
            if (ARB_MODE == ARB_ORDERED) begin
               if (sel_flush) begin
                  ptr_reg <= (ptr_reg == CH_W'(NUM_SRC - 1)) ? '0 : ptr_reg + CH_W'(1);
               end
            end else begin
               case (state_reg)
                  ARB_IDLE: begin
                     if (!sel_flush) begin
                        state_reg   <= ARB_LOCKED;
                        lock_ch_reg <= sel;
                     end
                  end
                  ARB_LOCKED: begin
                     if (sel_flush) begin
                        state_reg <= ARB_IDLE;
                     end
                  end
                  default: state_reg <= ARB_IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_bit_source_arbiter.sv
// tb_bit_source_arbiter
// Two arbiters share one set of producer inputs: d0 is ordered with 3 channels,
// d1 is priority-locked with 4 channels. A queue-based model of both is checked
// every cycle, and directed sequences check literal expectations.
module tb_bit_source_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        seq_restart = 1'b0;
   logic        out_ready = 1'b0;
   logic        en [4];
   logic        fl [4];
   logic [63:0] vals [4];
   logic [63:0] sizes [4];

   logic [2:0]   en0, fl0;
   logic [191:0] val0, size0;
   logic [3:0]   en1, fl1;
   logic [255:0] val1, size1;

   logic        o0_en, o0_fl, o1_en, o1_fl;
   logic [63:0] o0_val, o0_size, o1_val, o1_size;
   logic [1:0]  o0_ch, o1_ch;
   logic [2:0]  full0, ovf0, serr0;
   logic [3:0]  full1, ovf1, serr1;
   logic [31:0] bc0, bc1;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   always_comb begin
      en0 = '0; fl0 = '0; val0 = '0; size0 = '0;
      en1 = '0; fl1 = '0; val1 = '0; size1 = '0;
      for (int c = 0; c < 4; c++) begin
         en1[c] = en[c];
         fl1[c] = fl[c];
         val1[c*64 +: 64]  = vals[c];
         size1[c*64 +: 64] = sizes[c];
         if (c < 3) begin
            en0[c] = en[c];
            fl0[c] = fl[c];
            val0[c*64 +: 64]  = vals[c];
            size0[c*64 +: 64] = sizes[c];
         end
      end
   end

   bit_source_arbiter #(.NUM_SRC(3), .VAL_W(64), .SIZE_W(7), .FIFO_DEPTH(4), .ARB_MODE(0)) d0 (
      .clock(clock), .reset(reset), .seq_restart(seq_restart),
      .src_enable(en0), .src_flush(fl0), .src_val(val0), .src_size_of_bit(size0),
      .out_ready(out_ready), .out_enable(o0_en), .out_val(o0_val),
      .out_size_of_bit(o0_size), .out_flush(o0_fl), .out_channel(o0_ch),
      .src_full(full0), .overflow(ovf0), .size_err(serr0), .bit_count(bc0));

   bit_source_arbiter #(.NUM_SRC(4), .VAL_W(64), .SIZE_W(7), .FIFO_DEPTH(4), .ARB_MODE(1)) d1 (
      .clock(clock), .reset(reset), .seq_restart(seq_restart),
      .src_enable(en1), .src_flush(fl1), .src_val(val1), .src_size_of_bit(size1),
      .out_ready(out_ready), .out_enable(o1_en), .out_val(o1_val),
      .out_size_of_bit(o1_size), .out_flush(o1_fl), .out_channel(o1_ch),
      .src_full(full1), .overflow(ovf1), .size_err(serr1), .bit_count(bc1));

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        flush;
      logic [63:0] size;
      logic [63:0] val;
   } ent_t;

   ent_t        mq [8][$];       // queue index = dut*4 + channel
   int          m_ptr [2];
   bit          m_locked [2];
   int          m_lock_ch [2];
   logic        e_en [2], e_fl [2];
   logic [63:0] e_val [2], e_size [2];
   int          e_ch [2];
   logic [31:0] e_bc [2];
   logic [3:0]  e_ovf [2], e_serr [2];

   task automatic model_reset();
      for (int k = 0; k < 8; k++) mq[k].delete();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d] = 0; m_locked[d] = 0; m_lock_ch[d] = 0;
         e_en[d] = 0; e_fl[d] = 0; e_val[d] = 0; e_size[d] = 0;
         e_ch[d] = 0; e_bc[d] = 0; e_ovf[d] = 0; e_serr[d] = 0;
      end
   endtask

   task automatic model_step(input int d);
      int   n, sel;
      bit   popped;
      ent_t e, ne;
      n = (d == 0) ? 3 : 4;
      sel = -1;
      popped = 0;
      e = '0;
      if (d == 0) sel = m_ptr[d];
      else if (m_locked[d]) sel = m_lock_ch[d];
      else begin
         for (int c = n - 1; c >= 0; c--) if (mq[d*4+c].size() != 0) sel = c;
      end
      if (out_ready && sel >= 0 && mq[d*4+sel].size() != 0) begin
         popped = 1;
         e = mq[d*4+sel].pop_front();
      end
      // pushes see the queue after this cycle's pop, so a freed slot is usable
      for (int c = 0; c < n; c++) begin
         if (en[c] || fl[c]) begin
            ne.flush = fl[c];
            ne.size  = en[c] ? sizes[c] : 64'd0;
            ne.val   = en[c] ? vals[c] : 64'd0;
            if (ne.size > 64) begin
               ne.size = 64;
               e_serr[d][c] = 1'b1;
            end
            if (mq[d*4+c].size() < 4) mq[d*4+c].push_back(ne);
            else e_ovf[d][c] = 1'b1;
         end
      end
      e_en[d]   = popped && (e.size != 0);
      e_fl[d]   = popped && e.flush;
      e_val[d]  = popped ? e.val : 64'd0;
      e_size[d] = popped ? e.size : 64'd0;
      if (popped) e_ch[d] = sel;
      if (seq_restart) begin
         m_ptr[d] = 0; m_locked[d] = 0; e_bc[d] = 0;
      end else if (popped) begin
         e_bc[d] = e_bc[d] + e.size[31:0];
         if (d == 0) begin
            if (e.flush) m_ptr[d] = (m_ptr[d] + 1) % n;
         end else if (!m_locked[d] && !e.flush) begin
            m_locked[d] = 1; m_lock_ch[d] = sel;
         end else if (m_locked[d] && e.flush) begin
            m_locked[d] = 0;
         end
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) model_reset();
      else begin
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic        g_en, g_fl;
   logic [63:0] g_val, g_size;
   logic [1:0]  g_ch;
   logic [31:0] g_bc;
   logic [3:0]  g_full, g_ovf, g_serr, x_full;

   always @(negedge clock) begin
      for (int d = 0; d < 2; d++) begin
         if (d == 0) begin
            g_en = o0_en; g_fl = o0_fl; g_val = o0_val; g_size = o0_size; g_ch = o0_ch;
            g_bc = bc0; g_full = {1'b0, full0}; g_ovf = {1'b0, ovf0}; g_serr = {1'b0, serr0};
         end else begin
            g_en = o1_en; g_fl = o1_fl; g_val = o1_val; g_size = o1_size; g_ch = o1_ch;
            g_bc = bc1; g_full = full1; g_ovf = ovf1; g_serr = serr1;
         end
         x_full = '0;
         for (int c = 0; c < ((d == 0) ? 3 : 4); c++) x_full[c] = (mq[d*4+c].size() == 4);
         tests++;
         if (g_en !== e_en[d] || g_fl !== e_fl[d] || g_val !== e_val[d] ||
             g_size !== e_size[d] || g_ch !== 2'(e_ch[d]) || g_bc !== e_bc[d] ||
             g_full !== x_full || g_ovf !== e_ovf[d] || g_serr !== e_serr[d]) begin
            fails++;
            $display("FAIL cycle_d%0d t=%0t: got en=%b fl=%b val=%h size=%0d ch=%0d bc=%0d full=%b ovf=%b serr=%b; expected en=%b fl=%b val=%h size=%0d ch=%0d bc=%0d full=%b ovf=%b serr=%b",
                     d, $time, g_en, g_fl, g_val, g_size, g_ch, g_bc, g_full, g_ovf, g_serr,
                     e_en[d], e_fl[d], e_val[d], e_size[d], e_ch[d], e_bc[d], x_full, e_ovf[d], e_serr[d]);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      for (int c = 0; c < 4; c++) begin
         en[c] = 0; fl[c] = 0; vals[c] = 0; sizes[c] = 0;
      end
      seq_restart = 0;
   endtask

   task automatic push(input int ch, input logic [63:0] v, input logic [63:0] s, input logic f);
      en[ch] = 1; fl[ch] = f; vals[ch] = v; sizes[ch] = s;
   endtask

   task automatic push_flush_only(input int ch);
      fl[ch] = 1;
   endtask

   // one clock edge; returns 2 time units after it with inputs cleared
   task automatic cyc();
      @(posedge clock);
      #2;
      clear_inputs();
   endtask

   task automatic do_reset();
      reset = 1;
      @(posedge clock);
      #2;
      reset = 0;
      cyc();
   endtask

   initial begin
      clear_inputs();
      #1 reset = 1;
      @(posedge clock);
      #2;
      check("reset_out_enable", 64'(o0_en), 64'd0);
      check("reset_bit_count", 64'(bc1), 64'd0);
      reset = 0;
      cyc();

      // ordered: three channels pushed out of order, drained in channel order
      out_ready = 0;
      push(2, 64'hA, 64'd4, 0); cyc();
      push(0, 64'h5, 64'd3, 1); cyc();
      push_flush_only(1);       cyc();
      check("ord_idle_while_not_ready", 64'(o0_en), 64'd0);
      out_ready = 1;
      cyc();
      check("ord_frag0_val", o0_val, 64'h5);
      check("ord_frag0_size_flush_ch", {o0_size[31:0], 24'd0, 5'(o0_ch), o0_fl, o0_en}, {32'd3, 24'd0, 5'd0, 1'b1, 1'b1});
      cyc();
      check("ord_frag1_flush_only", {62'(o0_ch), o0_fl, o0_en}, {62'd1, 1'b1, 1'b0});
      cyc();
      check("ord_frag2", {o0_val[31:0], o0_size[15:0], 14'(o0_ch), o0_fl, o0_en}, {32'hA, 16'd4, 14'd2, 1'b0, 1'b1});
      check("ord_bit_count", 64'(bc0), 64'd7);

      // overflow with the sink stalled, then exactly four fragments drain
      do_reset();
      out_ready = 0;
      for (int k = 1; k <= 5; k++) begin
         push(0, 64'(k), 64'd8, 0);
         cyc();
         if (k == 4) begin
            check("ovf_full_after_4", 64'(full0[0]), 64'd1);
            check("ovf_clear_after_4", 64'(ovf0[0]), 64'd0);
         end
      end
      check("ovf_set_after_5", 64'(ovf0[0]), 64'd1);
      out_ready = 1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         check($sformatf("ovf_drain_%0d", k), {o0_val[62:0], o0_en}, (k <= 4) ? {63'(k), 1'b1} : 64'd0);
      end

      // priority lock: ch3 run drains through its flush before ch1, stall when empty
      do_reset();
      out_ready = 1;
      push(3, 64'h31, 64'd5, 0); cyc();
      check("pri_first_edge_idle", 64'(o1_en), 64'd0);
      push(1, 64'h11, 64'd2, 1); push(3, 64'h32, 64'd5, 0); cyc();
      check("pri_lock_ch3_a", {o1_val[61:0], o1_ch}, {62'h31, 2'd3});
      cyc();
      check("pri_lock_ch3_b", {o1_val[61:0], o1_ch}, {62'h32, 2'd3});
      push(3, 64'h33, 64'd5, 1); cyc();
      check("pri_locked_stall", 64'({o1_en, o1_fl}), 64'd0);
      cyc();
      check("pri_lock_ch3_flush", {o1_val[60:0], o1_fl, o1_ch}, {61'h33, 1'b1, 2'd3});
      cyc();
      check("pri_after_unlock_ch1", {o1_val[60:0], o1_fl, o1_ch}, {61'h11, 1'b1, 2'd1});
      check("pri_bit_count", 64'(bc1), 64'd17);

      // size clamp and sticky size_err
      do_reset();
      out_ready = 1;
      push(0, 64'hFF, 64'd80, 0); cyc();
      check("clamp_size_err", 64'(serr0[0]), 64'd1);
      cyc();
      check("clamp_out_size", o0_size, 64'd64);
      push(0, 64'h1, 64'd10, 0); cyc();
      cyc();
      check("clamp_sticky", {o0_size[62:0], serr0[0]}, {63'd10, 1'b1});

      // seq_restart coinciding with the ch1 flush pop
      do_reset();
      out_ready = 0;
      push(0, 64'h1, 64'd3, 1); cyc();
      push(1, 64'h2, 64'd4, 1); cyc();
      push(2, 64'h7, 64'd2, 0); cyc();
      push(0, 64'h9, 64'd1, 0); cyc();
      out_ready = 1;
      cyc();
      check("rst_seq_pop0_bc", {o0_val[29:0], bc0}, {30'h1, 32'd3});
      seq_restart = 1;
      cyc();
      check("rst_seq_pop1_ch", {60'(o0_val), 2'(o0_ch), o0_en, o0_fl}, {60'h2, 2'd1, 1'b1, 1'b1});
      check("rst_seq_bc_zero", 64'(bc0), 64'd0);
      cyc();
      check("rst_seq_ptr0", {60'(o0_val), 2'(o0_ch), 2'd0}, {60'h9, 2'd0, 2'd0});
      check("rst_seq_bc_one", 64'(bc0), 64'd1);

      // asynchronous reset mid-stream
      do_reset();
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         push(0, 64'h3, 64'd5, 0); push(2, 64'h4, 64'd6, 1); cyc();
      end
      out_ready = 1;
      cyc();
      check("areset_pre_active", {o0_val[62:0], o0_en}, {63'h3, 1'b1});
      reset = 1;
      #1;
      check("areset_immediate", {o0_en, o0_fl, o0_val[29:0], bc0}, 64'd0);
      check("areset_immediate_d1", {o1_en, o1_size[29:0], 1'b0, bc1}, 64'd0);
      @(posedge clock);
      #2;
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check($sformatf("areset_no_stale_%0d", k), {o0_en, o0_fl, o1_en, o1_fl, 60'(full0)}, 64'd0);
      end

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         for (int c = 0; c < 4; c++) begin
            en[c]    = ($urandom_range(0, 2) == 0);
            fl[c]    = ($urandom_range(0, 5) == 0);
            vals[c]  = {$urandom, $urandom};
            sizes[c] = ($urandom_range(0, 31) == 0) ? {32'h1, $urandom} : 64'($urandom_range(0, 80));
         end
         out_ready   = ($urandom_range(0, 3) != 0);
         seq_restart = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 600) == 0) begin
            reset = 1;
            @(posedge clock);
            #2;
            reset = 0;
            clear_inputs();
         end else begin
            cyc();
         end
      end
      clear_inputs();
      out_ready = 1;
      repeat (10) cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bit_source_arbiter.md
Name: bit_source_arbiter

Overview:
Parametrised successor to the OR-merge that feeds set_bit: NUM_SRC bitstream producers (frame header, matrix, picture header, slice size table, slice header, DC/AC VLC outputs, …) each get a private FIFO. A sequential arbiter drains the FIFOs into one registered {enable, val, size_of_bit, flush} stream for set_bit. It adds per-source buffering, backpressure, ordered/priority arbitration with run locking, and overflow detection, none of which the plain OR-merge has.

Parameters:
NUM_SRC, 8, number of producer channels (2..16)
VAL_W, 64, width of val per fragment
SIZE_W, 7, stored width of size_of_bit (holds 0..VAL_W)
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
ARB_MODE, 0, 0 = ordered (channel sequence), 1 = fixed priority with run lock

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
seq_restart  in  1  synchronous one-cycle pulse: new frame, pointer→0, bit counter cleared
src_enable  in  NUM_SRC  per-channel fragment valid
src_flush  in  NUM_SRC  per-channel flush marker (end of that source's run)
src_val  in  NUM_SRC*VAL_W  packed fragments, channel i at [i*VAL_W +: VAL_W]
src_size_of_bit  in  NUM_SRC*64  packed 64-bit sizes per channel
out_ready  in  1  set_bit can accept a fragment this cycle
out_enable  out  1  registered one-cycle fragment strobe
out_val  out  64  fragment, zero-extended from VAL_W
out_size_of_bit  out  64  fragment bit count, zero-extended
out_flush  out  1  registered flush strobe
out_channel  out  $clog2(NUM_SRC)  channel of current output
src_full  out  NUM_SRC  FIFO full per channel
overflow  out  NUM_SRC  sticky: write dropped on full FIFO
size_err  out  NUM_SRC  sticky: size_of_bit > VAL_W seen
bit_count  out  32  total bits emitted since reset/seq_restart, wraps

Behaviour:
- Reset (async, active-high): FIFOs emptied, pointer = 0, lock cleared. All outputs = 0.
- Push ch i: src_enable[i] | src_flush[i] writes {flush, size, val}. flush without enable writes size 0, val 0.
- size > VAL_W: stored as VAL_W, size_err[i] set.
- Push to full FIFO: dropped, overflow[i] set. Exception: push accepted when the same-cycle pop frees a slot.
- Pop: only when out_ready=1 and the selected channel's FIFO is non-empty.
  - Popped entry registers onto out_* next edge; out_enable = (size≠0), out_flush = flush bit.
  - When no pop occurs, out_enable, out_flush, out_val and out_size_of_bit are all 0 (idle-zero, OR-compatible).
- Latency: push at edge E → earliest out_enable at edge E+1. Throughput: 1 fragment/cycle.
- ARB_MODE 0 (ordered):
  - Select = pointer.
  - Popping an entry with flush=1 advances pointer (NUM_SRC-1 wraps to 0).
  - Other channels buffer until their turn; a full FIFO on a waiting channel overflows.
- ARB_MODE 1 (priority):
  - States IDLE / LOCKED.
  - IDLE: select lowest-index non-empty channel. Popping a non-flush entry → LOCKED on that channel.
  - LOCKED: select the locked channel only. Popping its flush entry → IDLE.
  - A locked but empty channel stalls output; no preemption.
- seq_restart:
  - Pointer → 0 (mode 0), lock → IDLE (mode 1), bit_count → 0.
  - FIFO contents kept.
  - If seq_restart coincides with a pop, the pop completes, but restart wins over pointer/lock update and the count for that pop is discarded.
- bit_count += popped size each pop; 32-bit wrap.
- out_channel registered alongside out_*.

Decomposition:
- Package bit_source_pkg holds:
  - typedef src_entry_t {flush, size[SIZE_W], val[VAL_W]}
  - ARB_ORDERED = 0 and ARB_PRIORITY = 1 constants
  - function for clamping size
- Sub-module bit_source_fifo (one per channel via generate):
  - single-clock, async-reset FIFO
  - push/pop/full/empty
  - simultaneous push+pop while full is legal
- Top contains arbiter FSM, output register and counters.

Test Plan:
- Mode 0, NUM_SRC=3. Ch2 pushes {val 0xA, size 4}, then ch0 pushes {0x5, 3, flush}, then ch1 pushes {flush}; out_ready=1 → output order ch0 (0x5/3, flush), ch1 (flush, enable 0), ch2 (0xA/4). bit_count = 7.
- out_ready held 0 while ch0 pushes 5 entries, FIFO_DEPTH=4 → src_full[0]=1, overflow[0]=1 after 5th push. Release out_ready → exactly 4 fragments out, in order.
- Mode 1: ch3 pushes a non-flush entry, then ch1 pushes while ch3 is locked → all ch3 entries through its flush drain before any ch1 entry. Lock to IDLE after ch3 flush.
- Size clamp: ch0 size 80, VAL_W 64 → out_size_of_bit 64, size_err[0]=1. Sticky after further legal pushes.
- seq_restart in the same cycle as a ch1 flush pop (mode 0, pointer 1) → pointer 0 next cycle, bit_count 0.
- Reset asserted mid-stream with FIFOs non-empty → outputs 0 immediately (async). After release, no stale fragments emitted.
